// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: ownership state and the DMType word code
// (the same code is used by the dm block).
package dm_arb_pkg;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DBG_OWN = 1'b1
  } dm_arb_state_e;

  localparam logic [2:0] DM_WORD = 3'b000;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU MEM-stage port, debug/loader port and dm port around dm_arbiter.
// The slave modport is the arbiter's view; master is the surrounding SoC/board logic.
interface dm_arbiter_if #(
  parameter int unsigned LEN_W = 4
);
  logic             cpu_re;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [2:0]       cpu_dmtype;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;

  logic             dbg_req;
  logic             dbg_we;
  logic [LEN_W-1:0] dbg_len;
  logic [31:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic             dbg_gnt;
  logic             dbg_rvalid;
  logic [31:0]      dbg_rdata;
  logic             dbg_done;

  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_din;
  logic [2:0]       dm_dmtype;
  logic [31:0]      dm_dout;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    input  dbg_req, dbg_we, dbg_len, dbg_addr, dbg_wdata,
    input  dm_dout,
    output cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_done,
    output dm_we, dm_addr, dm_din, dm_dmtype
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    output dbg_req, dbg_we, dbg_len, dbg_addr, dbg_wdata,
    output dm_dout,
    input  cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_done,
    input  dm_we, dm_addr, dm_din, dm_dmtype
  );

endinterface

// File: rtl/dm_arb_mux.sv
// Combinational 2:1 selection of the dm access between the CPU and the debug port.
module dm_arb_mux
  import dm_arb_pkg::*;
(
  input  dm_arb_state_e sel_i,
  input  logic          cpu_we_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  input  logic [2:0]    cpu_dmtype_i,
  input  logic          dbg_we_i,
  input  logic [31:0]   dbg_addr_i,
  input  logic [31:0]   dbg_wdata_i,
  output logic          dm_we_o,
  output logic [31:0]   dm_addr_o,
  output logic [31:0]   dm_din_o,
  output logic [2:0]    dm_dmtype_o
);

  always_comb begin
    dm_we_o     = cpu_we_i;
    dm_addr_o   = cpu_addr_i;
    dm_din_o    = cpu_wdata_i;
    dm_dmtype_o = cpu_dmtype_i;
    if (sel_i == DBG_OWN) begin
      dm_we_o     = dbg_we_i;
      dm_addr_o   = dbg_addr_i;
      dm_din_o    = dbg_wdata_i;
      dm_dmtype_o = DM_WORD;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU owns dm by default, the debug port takes it for bounded bursts.
// Define DM_ARB_FAIRNESS_EN to force a starved debug request in after MAX_WAIT cycles.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned LEN_W    = 4
) (
  input logic          clk,
  input logic          rst,
  dm_arbiter_if.slave  bus
);

  dm_arb_state_e    state_q, state_d, owner;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             rvalid_q, rvalid_d;
  logic             done_q, done_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             gnt, stall, cpu_busy, starve;

  assign cpu_busy = bus.cpu_re | bus.cpu_we;

`ifdef DM_ARB_FAIRNESS_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  assign starve = (wait_q == WAIT_W'(MAX_WAIT - 1));
`else
  assign starve = 1'b0;
`endif

  // During reset the outputs must look like CPU_OWN even if a burst was in flight.
  assign owner = rst ? CPU_OWN : state_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    gnt      = 1'b0;
    stall    = 1'b0;
`ifdef DM_ARB_FAIRNESS_EN
    wait_d   = wait_q;
`endif
    case (owner)
      CPU_OWN: begin
        if (bus.dbg_req && (!cpu_busy || starve)) begin
          state_d = DBG_OWN;
          beat_d  = bus.dbg_len;
`ifdef DM_ARB_FAIRNESS_EN
          wait_d  = '0;
        end else if (bus.dbg_req) begin
          wait_d  = wait_q + 1'b1;
        end else begin
          wait_d  = '0;
`endif
        end
      end
      DBG_OWN: begin
        gnt   = bus.dbg_req;
        stall = cpu_busy;
        if (!bus.dbg_req) begin
          state_d = CPU_OWN;
        end else begin
          if (!bus.dbg_we) begin
            rvalid_d = 1'b1;
            rdata_d  = bus.dm_dout;
          end
          if (beat_q == '0) begin
            state_d = CPU_OWN;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q - 1'b1;
          end
        end
      end
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CPU_OWN;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef DM_ARB_FAIRNESS_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
`ifdef DM_ARB_FAIRNESS_EN
      wait_q   <= wait_d;
`endif
    end
  end

  dm_arb_mux u_mux (
    .sel_i        (owner),
    .cpu_we_i     (bus.cpu_we),
    .cpu_addr_i   (bus.cpu_addr),
    .cpu_wdata_i  (bus.cpu_wdata),
    .cpu_dmtype_i (bus.cpu_dmtype),
    .dbg_we_i     (bus.dbg_we & bus.dbg_req),
    .dbg_addr_i   (bus.dbg_addr),
    .dbg_wdata_i  (bus.dbg_wdata),
    .dm_we_o      (bus.dm_we),
    .dm_addr_o    (bus.dm_addr),
    .dm_din_o     (bus.dm_din),
    .dm_dmtype_o  (bus.dm_dmtype)
  );

  assign bus.cpu_rdata  = bus.dm_dout;
  assign bus.cpu_stall  = stall;
  assign bus.dbg_gnt    = gnt;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_done   = done_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed bursts push expected grants/read data/done
// pulses/CPU load data; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_arbiter_if #(.LEN_W(LEN_W)) bus ();

  dm_arbiter #(.MAX_WAIT(8), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // dm model: combinational read, write on the rising edge
  logic [31:0] mem [0:255];
  assign bus.dm_dout = mem[bus.dm_addr[9:2]];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[9:2]] <= bus.dm_din;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [31:0] addr; logic we; } gnt_t;
  typedef struct { int unsigned cyc; logic [31:0] data; } rd_t;

  gnt_t        exp_gnt [$];
  rd_t         exp_rd  [$];
  int unsigned exp_done[$];
  logic [31:0] exp_cpu [$];
  logic [31:0] wdat [4];

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned gnt_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output %h presented with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    gnt_t g;
    rd_t  r;
    if (bus.dbg_gnt) begin
      gnt_seen++;
      if (exp_gnt.size() == 0) unexpected("gnt", bus.dm_addr);
      else begin
        g = exp_gnt.pop_front();
        chk("gnt_cycle", cyc, g.cyc);
        chk("gnt_addr", bus.dm_addr, g.addr);
        chk("gnt_dm_we", {31'b0, bus.dm_we}, {31'b0, g.we});
        chk("gnt_dmtype", {29'b0, bus.dm_dmtype}, {29'b0, DM_WORD});
      end
    end
    if (bus.dbg_rvalid) begin
      if (exp_rd.size() == 0) unexpected("rvalid", bus.dbg_rdata);
      else begin
        r = exp_rd.pop_front();
        chk("rvalid_cycle", cyc, r.cyc);
        chk("rdata", bus.dbg_rdata, r.data);
      end
    end
    if (bus.dbg_done) begin
      if (exp_done.size() == 0) unexpected("done", cyc);
      else chk("done_cycle", cyc, exp_done.pop_front());
    end
    if (!rst && bus.cpu_re && !bus.cpu_stall) begin
      if (exp_cpu.size() == 0) unexpected("cpu_load", bus.cpu_rdata);
      else chk("cpu_rdata", bus.cpu_rdata, exp_cpu.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic push_gnt(input int unsigned c, input logic [31:0] a, input logic we);
    gnt_t g;
    g.cyc = c; g.addr = a; g.we = we;
    exp_gnt.push_back(g);
  endtask

  task automatic push_rd(input int unsigned c, input logic [31:0] d);
    rd_t r;
    r.cyc = c; r.data = d;
    exp_rd.push_back(r);
  endtask

  task automatic cpu_load(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = a;
    exp_cpu.push_back(d);
    tick();
    bus.cpu_re = 1'b0;
  endtask

  // Requester: hold dbg_req, advance the address after each granted beat.
  task automatic dbg_burst(input logic we, input int unsigned nbeats, input logic [31:0] base,
                           input int unsigned stop_after, input logic keep_req);
    int unsigned beats = 0;
    int unsigned guard = 0;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_len   = LEN_W'(nbeats - 1);
    bus.dbg_addr  = base;
    bus.dbg_wdata = wdat[0];
    while (beats < stop_after && guard < 40) begin
      @(negedge clk);
      if (bus.dbg_gnt) beats++;
      guard++;
      tick();
      bus.dbg_addr  = base + 32'(4 * beats);
      bus.dbg_wdata = wdat[beats % 4];
    end
    if (!keep_req) bus.dbg_req = 1'b0;
    chk("burst_beats", beats, stop_after);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    int unsigned n;
    int unsigned g0;
    logic        stall_exp;

    for (int unsigned i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
    rst            = 1'b1;
    bus.cpu_re     = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_dmtype = DM_WORD;
    bus.dbg_req    = 1'b1;
    bus.dbg_we     = 1'b0;
    bus.dbg_len    = LEN_W'(3);
    bus.dbg_addr   = 32'h40;
    bus.dbg_wdata  = '0;
    for (int unsigned i = 0; i < 4; i++) wdat[i] = '0;

    // reset held two cycles with a pending 4-beat read
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", {31'b0, bus.dbg_gnt}, 32'd0);
      chk("rst_done", {31'b0, bus.dbg_done}, 32'd0);
      chk("rst_stall", {31'b0, bus.cpu_stall}, 32'd0);
    end
    chk("rst_rvalid", {31'b0, bus.dbg_rvalid}, 32'd0);
    chk("rst_rdata", bus.dbg_rdata, 32'd0);
    tick();
    rst = 1'b0;
    t = cyc;
    for (int unsigned i = 0; i < 4; i++) begin
      push_gnt(t + 1 + i, 32'h40 + 32'(4 * i), 1'b0);
      push_rd(t + 2 + i, 32'hC0DE_0010 + i);
    end
    exp_done.push_back(t + 5);
    dbg_burst(1'b0, 4, 32'h40, 4, 1'b0);
    idle(3);

    // 2-beat write burst, then CPU reads it back
    wdat[0] = 32'hA5A5_A5A5;
    wdat[1] = 32'h5A5A_5A5A;
    t = cyc;
    push_gnt(t + 1, 32'h10, 1'b1);
    push_gnt(t + 2, 32'h14, 1'b1);
    exp_done.push_back(t + 3);
    dbg_burst(1'b1, 2, 32'h10, 2, 1'b0);
    idle(1);
    cpu_load(32'h10, 32'hA5A5_A5A5);
    cpu_load(32'h14, 32'h5A5A_5A5A);
    idle(2);

    // single-beat read: rvalid exactly one cycle after the grant
    t = cyc;
    push_gnt(t + 1, 32'h10, 1'b0);
    push_rd(t + 2, 32'hA5A5_A5A5);
    exp_done.push_back(t + 2);
    dbg_burst(1'b0, 1, 32'h10, 1, 1'b0);
    idle(2);

    // CPU loads every cycle while the debug port asks for one beat
    t  = cyc;
    g0 = gnt_seen;
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_len  = '0;
    bus.dbg_addr = 32'h20;
    bus.cpu_addr = 32'h20;
`ifdef DM_ARB_FAIRNESS_EN
    n = 12;
    push_gnt(t + 8, 32'h20, 1'b0);
    push_rd(t + 9, 32'hC0DE_0008);
    exp_done.push_back(t + 9);
`else
    n = 50;
`endif
    for (int unsigned k = 0; k < n; k++) begin
`ifdef DM_ARB_FAIRNESS_EN
      if (k == 9) bus.dbg_req = 1'b0;
      stall_exp = (k == 8);
`else
      stall_exp = 1'b0;
`endif
      bus.cpu_re = 1'b1;
      if (!stall_exp) exp_cpu.push_back(32'hC0DE_0008);
      @(negedge clk);
      chk("starve_stall", {31'b0, bus.cpu_stall}, {31'b0, stall_exp});
      tick();
    end
    bus.dbg_req = 1'b0;
    bus.cpu_re  = 1'b0;
`ifndef DM_ARB_FAIRNESS_EN
    chk("starve_no_gnt", gnt_seen - g0, 32'd0);
`endif
    idle(2);

    // abort after 2 of 4 beats
    wdat[0] = 32'hCAFE_0001;
    wdat[1] = 32'hCAFE_0002;
    wdat[2] = 32'hCAFE_0003;
    wdat[3] = 32'hCAFE_0004;
    t = cyc;
    push_gnt(t + 1, 32'h60, 1'b1);
    push_gnt(t + 2, 32'h64, 1'b1);
    dbg_burst(1'b1, 4, 32'h60, 2, 1'b0);
    @(negedge clk);
    chk("abort_dm_we", {31'b0, bus.dm_we}, 32'd0);
    chk("abort_stall", {31'b0, bus.cpu_stall}, 32'd0);
    tick();
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h68;
    bus.cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("abort_cpu_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("abort_cpu_we", {31'b0, bus.dm_we}, 32'd1);
    chk("abort_cpu_addr", bus.dm_addr, 32'h68);
    tick();
    bus.cpu_we = 1'b0;
    cpu_load(32'h68, 32'h1234_5678);
    cpu_load(32'h60, 32'hCAFE_0001);
    cpu_load(32'h64, 32'hCAFE_0002);
    cpu_load(32'h6C, 32'hC0DE_001B);
    idle(2);

    // reset pulsed after 2 of 4 write beats
    wdat[0] = 32'h1111_1111;
    wdat[1] = 32'h2222_2222;
    wdat[2] = 32'h3333_3333;
    wdat[3] = 32'h4444_4444;
    t = cyc;
    push_gnt(t + 1, 32'h80, 1'b1);
    push_gnt(t + 2, 32'h84, 1'b1);
    dbg_burst(1'b1, 4, 32'h80, 2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dm_we", {31'b0, bus.dm_we}, 32'd0);
    chk("midrst_gnt", {31'b0, bus.dbg_gnt}, 32'd0);
    tick();
    rst         = 1'b0;
    bus.dbg_req = 1'b0;
    cpu_load(32'h8C, 32'hC0DE_0023);
    cpu_load(32'h88, 32'hC0DE_0022);
    cpu_load(32'h80, 32'h1111_1111);
    cpu_load(32'h84, 32'h2222_2222);
    idle(3);

    chk("left_gnt", exp_gnt.size(), 32'd0);
    chk("left_rd", exp_rd.size(), 32'd0);
    chk("left_done", exp_done.size(), 32'd0);
    chk("left_cpu", exp_cpu.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Single-port data-memory arbiter sitting between the pipeline CPU's MEM-stage data port and the `dm` instance in the SoC top. It shares the memory with a second requester: a debug/loader port driven from the FPGA board logic, used to preload or inspect RAM. The CPU has default ownership. The debug port wins the memory for bounded bursts, and the CPU is stalled while it waits.

## Interface
Parameters:
- `MAX_WAIT`, default 8: cycles a pending debug request may be starved before it is forced in (fairness build only).
- `LEN_W`, default 4: width of the burst-length field; a burst is 1..2^LEN_W beats.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cpu_re`  in  1  CPU MEM-stage load this cycle.
- `cpu_we`  in  1  CPU MEM-stage store this cycle.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU store data.
- `cpu_dmtype`  in  3  CPU access type (byte/half/word, signed/unsigned).
- `cpu_rdata`  out  32  load data returned to the CPU (combinational from `dm_dout`).
- `cpu_stall`  out  1  freeze the pipeline; the CPU holds its access and retries.
- `dbg_req`  in  1  debug port requests the memory; held high for the whole burst.
- `dbg_we`  in  1  1 = write burst, 0 = read burst.
- `dbg_len`  in  LEN_W  burst length minus 1; sampled on entry to `DBG_OWN`.
- `dbg_addr`  in  32  beat address; the requester advances it after each granted beat.
- `dbg_wdata`  in  32  beat write data.
- `dbg_gnt`  out  1  current beat is issued to memory this cycle.
- `dbg_rvalid`  out  1  registered read data valid, one cycle after a granted read beat.
- `dbg_rdata`  out  32  registered read data.
- `dbg_done`  out  1  one-cycle pulse in the cycle after the last beat.
- `dm_we`  out  1  write enable to `dm`.
- `dm_addr`  out  32  address to `dm`.
- `dm_din`  out  32  write data to `dm`.
- `dm_dmtype`  out  3  access type to `dm`.
- `dm_dout`  in  32  read data from `dm` (combinational read).

## Operation
- States: `CPU_OWN` (reset state) and `DBG_OWN`.
- **In `CPU_OWN`:**
  - The memory mux selects the CPU; `dm_we = cpu_we`.
  - `dbg_gnt = 0` and `cpu_stall = 0`.
- **`CPU_OWN` → `DBG_OWN`:** taken when `dbg_req` is high and either:
  - the CPU is idle this cycle (`cpu_re | cpu_we` = 0), or
  - the fairness build is in and `wait_cnt == MAX_WAIT-1`.
  - On entry: `beat_cnt <= dbg_len`, `wait_cnt <= 0`.
- **In `DBG_OWN`:**
  - The mux selects the debug port; `dm_dmtype` is forced to word.
  - `dm_we = dbg_we & dbg_req`.
  - `dbg_gnt = dbg_req`.
  - `cpu_stall = cpu_re | cpu_we`.
- **Beat counting:** each granted beat decrements `beat_cnt`. The beat granted with `beat_cnt == 0` is the last beat; the next state is `CPU_OWN` and `dbg_done` pulses the following cycle.
- **Abort:** if `dbg_req` drops in `DBG_OWN`, no beat is issued, the FSM returns to `CPU_OWN` next cycle, and `dbg_done` does not pulse.
- **Read beats:** `dbg_rdata <= dm_dout` and `dbg_rvalid <= 1` on the edge after each granted read beat; otherwise `dbg_rvalid <= 0`.
- **Reset values:**
  - state `CPU_OWN`; `beat_cnt`, `wait_cnt` = 0.
  - `dbg_rvalid`, `dbg_done` = 0; `dbg_rdata` = 0.
  - Combinational outputs follow the `CPU_OWN` equations.
- **Reset mid-burst:** no `dm_we` is issued in the reset cycle; the remaining beats are discarded.
- `dbg_req` and a CPU access in the same `CPU_OWN` cycle: the CPU wins (the fairness build overrides this at the starvation limit).

## Timing
- `dbg_req` rises in cycle 0 with the CPU idle:
  - state is `DBG_OWN` in cycle 1 and the first beat is granted in cycle 1;
  - an N-beat burst occupies cycles 1..N;
  - `dbg_done` pulses in cycle N+1, where the CPU owns memory again.
- Read data latency: `dbg_rvalid` one cycle after `dbg_gnt`.
- CPU load data: same cycle as its access; zero added latency when not stalled.
- Back-to-back bursts: at least one `CPU_OWN` cycle between them, because `dbg_req` must be re-evaluated.

## Configuration
- `DM_ARB_FAIRNESS_EN` defined:
  - `wait_cnt` increments each `CPU_OWN` cycle with `dbg_req` high and the CPU busy;
  - it clears when `dbg_req` is low or on entering `DBG_OWN`;
  - at `MAX_WAIT-1` the FSM forces `DBG_OWN` and stalls the CPU.
- Undefined: strict CPU priority; `wait_cnt` is absent; the debug port may starve indefinitely.

## Structure
- Shared package `dm_arb_pkg`:
  - state enum `CPU_OWN=1'b0`, `DBG_OWN=1'b1`;
  - DMType word constant `DM_WORD=3'b000`, also used by `dm`.
- Sub-module `dm_arb_mux`: purely combinational 2:1 selection of `dm_we`/`dm_addr`/`dm_din`/`dm_dmtype` by owner.
- FSM and counters live in `dm_arbiter`.

## Test plan
- Reset held 2 cycles with `dbg_req=1`, `dbg_len=3` → `dbg_gnt=0` and `dbg_done=0` throughout; after release with the CPU idle, beats granted in cycles 1–4 and `dbg_done` in cycle 5.
- CPU idle, debug write burst `dbg_len=1`, addresses 0x10 and 0x14, data 0xA5A5A5A5 and 0x5A5A5A5A → a subsequent CPU `lw` from 0x10 and 0x14 returns those values.
- Debug read burst of 1 beat at 0x10 → `dbg_rvalid=1` and `dbg_rdata=0xA5A5A5A5` exactly one cycle after `dbg_gnt`.
- CPU issuing loads every cycle plus a pending `dbg_req`:
  - without the macro, `dbg_gnt` never asserts over 50 cycles;
  - with the macro and `MAX_WAIT=8`, `DBG_OWN` is entered on cycle 8 and `cpu_stall=1` during the burst.
- `dbg_req` dropped after 2 of 4 beats → FSM back in `CPU_OWN` next cycle, `dbg_done` stays 0, the next CPU store is accepted.
- `rst` pulsed in the middle of a 4-beat write burst → no `dm_we` in the reset cycle, remaining addresses unmodified, FSM in `CPU_OWN`.
